// File: rtl/instr_mem_param.sv
// Loadable, synchronous instruction memory: self-clearing after reset,
// registered fetch port with stall, auto-incrementing load port.
module instr_mem_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic                  addr_error,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ready,
  output logic                  dbg_state_o
);

  // Handshake: a fetch is accepted on a rising edge where the block is in RUN,
  // fetch_req=1 and stall=0; its result appears one cycle later with
  // instr_valid=1. While stall=1 all fetch outputs hold.

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_q;
  logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic                    valid_q, err_q, ready_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   eff_ptr;
  logic                    load_in_range;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    fetch_in_range;
  logic [DATA_WIDTH-1:0]   rd_data;

  always_comb begin
    eff_ptr       = load_start ? load_addr : wptr_q;
    load_in_range = ({1'b0, eff_ptr} < DEPTH_W);

    wptr_d = wptr_q;
    if (load_en) begin
      // Out-of-range pointers keep counting modulo 2**ADDR_WIDTH until they wrap.
      wptr_d = (eff_ptr == LAST) ? '0 : eff_ptr + 1'b1;
    end else if (load_start) begin
      wptr_d = load_addr;
    end

    wr_en   = 1'b0;
    wr_addr = eff_ptr;
    wr_data = load_data;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_q;
        wr_data = '0;
      end else begin
        wr_en = load_en && load_in_range;
      end
    end

    fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
    // Write-first: a same-cycle write to the fetched word is forwarded.
    rd_data = (wr_en && (wr_addr == fetch_addr)) ? wr_data : mem_q[fetch_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
      wptr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_q == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_q <= clr_q + 1'b1;
          end
        end
        ST_RUN: begin
          wptr_q <= wptr_d;
          if (!stall) begin
            if (fetch_req) begin
              valid_q <= 1'b1;
              if (fetch_in_range) begin
                instr_q <= rd_data;
                err_q   <= 1'b0;
              end else begin
                instr_q <= '0;
                err_q   <= 1'b1;
              end
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign addr_error  = err_q;
  assign ready       = ready_q;
  assign dbg_state_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_mem_param.sv
// Bench for instr_mem_param: DEPTH=64 and DEPTH=48 instances driven in
// lockstep and compared every cycle against a behavioural memory model.
module tb_instr_mem_param;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fetch_req, stall, load_start, load_en;
  logic [AW-1:0] fetch_addr, load_addr;
  logic [DW-1:0] load_data;

  logic [DW-1:0] out_a, out_b;
  logic          valid_a, valid_b, err_a, err_b, ready_a, ready_b, dbg_a, dbg_b;

  instr_mem_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(64)) u_d64 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .instr_out(out_a), .instr_valid(valid_a), .addr_error(err_a),
    .load_start(load_start), .load_addr(load_addr), .load_en(load_en),
    .load_data(load_data), .ready(ready_a), .dbg_state_o(dbg_a)
  );

  instr_mem_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(48)) u_d48 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .instr_out(out_b), .instr_valid(valid_b), .addr_error(err_b),
    .load_start(load_start), .load_addr(load_addr), .load_en(load_en),
    .load_data(load_data), .ready(ready_b), .dbg_state_o(dbg_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a plain word array per instance, cleared as a whole on rst,
  // with a count of remaining clear cycles before the memory serves requests.
  int            dep [2] = '{64, 48};
  logic [DW-1:0] m_mem [2][64];
  int            m_ptr [2];
  int            m_clr [2];
  logic [DW-1:0] m_out [2];
  logic          m_valid [2], m_err [2], m_ready [2];

  task automatic model_step(input int i);
    int p;
    if (rst) begin
      for (int a = 0; a < 64; a++) m_mem[i][a] = '0;
      m_ptr[i] = 0; m_clr[i] = dep[i];
      m_out[i] = '0; m_valid[i] = 1'b0; m_err[i] = 1'b0; m_ready[i] = 1'b0;
    end else if (m_clr[i] > 0) begin
      m_clr[i]--;
      if (m_clr[i] == 0) m_ready[i] = 1'b1;
    end else begin
      p = load_start ? int'(load_addr) : m_ptr[i];
      if (load_en) begin
        if (p < dep[i]) m_mem[i][p] = load_data;
        m_ptr[i] = (p == dep[i] - 1) ? 0 : (p + 1) % (1 << AW);
      end else if (load_start) begin
        m_ptr[i] = int'(load_addr);
      end
      if (!stall) begin
        if (fetch_req) begin
          m_valid[i] = 1'b1;
          if (int'(fetch_addr) < dep[i]) begin
            m_out[i] = m_mem[i][fetch_addr];
            m_err[i] = 1'b0;
          end else begin
            m_out[i] = '0;
            m_err[i] = 1'b1;
          end
        end else begin
          m_valid[i] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic check_outputs();
    check($sformatf("d64.instr_out@%0d", cyc), out_a, m_out[0]);
    check($sformatf("d64.instr_valid@%0d", cyc), DW'(valid_a), DW'(m_valid[0]));
    check($sformatf("d64.addr_error@%0d", cyc), DW'(err_a), DW'(m_err[0]));
    check($sformatf("d64.ready@%0d", cyc), DW'(ready_a), DW'(m_ready[0]));
    check($sformatf("d48.instr_out@%0d", cyc), out_b, m_out[1]);
    check($sformatf("d48.instr_valid@%0d", cyc), DW'(valid_b), DW'(m_valid[1]));
    check($sformatf("d48.addr_error@%0d", cyc), DW'(err_b), DW'(m_err[1]));
    check($sformatf("d48.ready@%0d", cyc), DW'(ready_b), DW'(m_ready[1]));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    load_start = 1'b0; load_addr = '0; load_en = 1'b0; load_data = '0;
  endtask

  task automatic fetch(input int a);
    fetch_req = 1'b1; fetch_addr = AW'(a);
    step();
    fetch_req = 1'b0;
  endtask

  task automatic load_word(input logic start, input int a, input logic [DW-1:0] d);
    load_start = start; load_addr = AW'(a); load_en = 1'b1; load_data = d;
    step();
    load_start = 1'b0; load_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int rise_a, rise_b;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Clear sequence: ready must rise exactly DEPTH cycles after rst falls.
    rise_a = 0; rise_b = 0;
    for (int n = 1; n <= 70; n++) begin
      step();
      if (ready_a && rise_a == 0) rise_a = n;
      if (ready_b && rise_b == 0) rise_b = n;
    end
    check("ready_rise_d64", DW'(rise_a), DW'(64));
    check("ready_rise_d48", DW'(rise_b), DW'(48));

    fetch(5);
    check("cleared_word5", out_a, 32'h0);

    // Load three words from 0, then fetch back-to-back.
    load_word(1'b1, 0, 32'h00200005);
    load_word(1'b0, 0, 32'h00E00001);
    load_word(1'b0, 0, 32'h10640027);
    fetch_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      fetch_addr = AW'(a);
      step();
    end
    fetch_req = 1'b0;
    check("fetch_word2", out_a, 32'h10640027);

    // Stall holds the previous result.
    fetch_req = 1'b1; fetch_addr = AW'(1);
    step();
    stall = 1'b1; fetch_addr = AW'(2);
    for (int k = 0; k < 3; k++) step();
    check("stall_hold", out_a, 32'h00E00001);
    stall = 1'b0;
    step();
    check("stall_release", out_a, 32'h10640027);
    fetch_req = 1'b0;
    step();

    // Wrap at DEPTH-1 and out-of-range fetch.
    load_word(1'b1, 47, 32'hAAAA0047);
    load_word(1'b0, 0, 32'hBBBB0000);
    fetch(47);
    fetch(0);
    check("wrap_d48_word0", out_b, 32'hBBBB0000);
    fetch(48);
    fetch(50);
    check("oor_d48_err", DW'(err_b), DW'(1));

    // Same-cycle write and fetch of address 3.
    fetch_req = 1'b1; fetch_addr = AW'(3);
    load_word(1'b1, 3, 32'hDEADBEEF);
    fetch_req = 1'b0;
    check("bypass_d64", out_a, 32'hDEADBEEF);
    check("bypass_d48", out_b, 32'hDEADBEEF);

    // Reset in the middle of a load burst.
    load_start = 1'b1; load_addr = AW'(10); load_en = 1'b1; load_data = 32'h11110010;
    step();
    load_start = 1'b0; load_data = 32'h11110011;
    step();
    rst = 1'b1; load_data = 32'h11110012;
    step();
    check("rst_ready_low", DW'(ready_a), DW'(0));
    idle();
    for (int n = 0; n < 66; n++) step();
    for (int a = 10; a < 13; a++) fetch(a);
    fetch(3);
    check("post_rst_word3", out_a, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 249) == 0);
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
      stall      = ($urandom_range(0, 3) == 0);
      load_start = ($urandom_range(0, 7) == 0);
      load_addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
      load_en    = ($urandom_range(0, 1) == 0);
      load_data  = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
